// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART command frame collector driving the ALU; optional inter-byte timeout via UART_ALU_TIMEOUT_EN
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_A,
  output logic [NB_DATA-1:0] o_alu_B,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   timeout;

`ifdef UART_ALU_TIMEOUT_EN
  logic [31:0] timeout_cnt;
  logic        waiting_byte;

  assign waiting_byte = (state == S_B) || (state == S_OP);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = waiting_byte && !i_rx_done &&
                   (timeout_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter; restarts on every received byte and outside S_B/S_OP.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timeout_cnt <= '0;
    end else if (!waiting_byte || i_rx_done || timeout) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: collect A, B, op; one settle cycle; wait for transmitter.
  always_comb begin
    next_state = state;
    case (state)
      S_A:    if (i_rx_done) next_state = S_B;
      S_B:    if (i_rx_done) next_state = S_OP;
              else if (timeout) next_state = S_A;
      S_OP:   if (i_rx_done) next_state = S_CALC;
              else if (timeout) next_state = S_A;
      S_CALC: next_state = S_SEND;
      S_SEND: if (i_tx_done) next_state = S_A;
      default: next_state = S_A;
    endcase
  end

  // Operand/result registers; operands persist between frames, tx_start is a one-cycle pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= (state == S_CALC);
      if (state == S_A && i_rx_done) o_alu_A <= i_rx_data;
      if (state == S_B && i_rx_done) o_alu_B <= i_rx_data;
      if (state == S_OP && i_rx_done) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (state == S_CALC) o_tx_data <= i_alu_result;
    end
  end

  assign o_busy = (state == S_CALC) || (state == S_SEND);

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - scoreboard bench for uart_alu_interface with a reference ALU model
module tb_uart_alu_interface;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_alu_A;
  logic [7:0] o_alu_B;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;

  uart_alu_interface #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done),
    .i_alu_result(i_alu_result),
    .i_tx_done(i_tx_done),
    .o_alu_A(o_alu_A),
    .o_alu_B(o_alu_B),
    .o_alu_op(o_alu_op),
    .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU: also serves as the combinational ALU attached to the DUT.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return sa >>> b;
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = alu_ref(o_alu_A, o_alu_B, o_alu_op);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         op_edge;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   starts_seen = 0;
  exp_t mon_e;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every tx_start pulse must match the oldest outstanding frame.
  always @(negedge i_clk) begin
    if (!i_reset && o_tx_start) begin
      starts_seen++;
      if (sb.size() == 0) begin
        check("unexpected_tx_start", 32'(o_tx_start), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("tx_data", 32'(o_tx_data), 32'(mon_e.res));
        check("alu_A", 32'(o_alu_A), 32'(mon_e.a));
        check("alu_B", 32'(o_alu_B), 32'(mon_e.b));
        check("alu_op", 32'(o_alu_op), 32'(mon_e.op));
        check("tx_start_latency", 32'(cyc), 32'(mon_e.op_edge + 1));
        check("busy_at_tx_start", 32'(o_busy), 32'd1);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic pulse_rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"}, 32'(o_alu_A), 32'd0);
    check({tag, "_B"}, 32'(o_alu_B), 32'd0);
    check({tag, "_op"}, 32'(o_alu_op), 32'd0);
    check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gmax, input bit junk, input bit collide, input bit stray);
    exp_t e;
    int   prev;
    e.a   = a;
    e.b   = b;
    e.op  = 6'(opb % 8'd64);
    e.res = alu_ref(a, b, e.op);
    pulse_rx(a);
    if (stray) begin
      i_tx_done = 1'b1;
      @(posedge i_clk);
      #1;
      i_tx_done = 1'b0;
    end
    idle($urandom_range(gmax, 0));
    pulse_rx(b);
    idle($urandom_range(gmax, 0));
    prev = starts_seen;
    pulse_rx(opb);
    e.op_edge = cyc;
    sb.push_back(e);
    for (int i = 0; i < 20 && starts_seen == prev; i++) @(negedge i_clk);
    check("tx_start_seen", 32'(starts_seen), 32'(prev + 1));
    @(posedge i_clk);
    #1;
    if (junk) begin
      pulse_rx(8'hAA);
      pulse_rx(8'hBB);
    end
    idle($urandom_range(gmax, 0));
    check("busy_in_send", 32'(o_busy), 32'd1);
    i_tx_done = 1'b1;
    if (collide) begin
      i_rx_data = 8'($urandom);
      i_rx_done = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    check("busy_after_tx_done", 32'(o_busy), 32'd0);
    check("hold_A", 32'(o_alu_A), 32'(a));
    check("hold_op", 32'(o_alu_op), 32'(e.op));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ops[8];
    logic [7:0] opb;
    int         prev;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    i_rx_data = 8'h00;
    #1;
    check_all_zero("reset");
    idle(3);
    i_reset = 1'b0;

    run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h10, 8'h04, 8'hE2, 0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h33, 8'h11, 8'h24, 1, 1'b1, 1'b0, 1'b0);
    run_frame(8'h0F, 8'h01, 8'h22, 0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h81, 8'h02, 8'h03, 2, 1'b0, 1'b1, 1'b1);
    run_frame(8'h40, 8'h40, 8'h20, 0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    pulse_rx(8'h11);
    #3;
    i_reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    run_frame(8'h21, 8'h12, 8'h26, 0, 1'b0, 1'b0, 1'b0);

`ifdef UART_ALU_TIMEOUT_EN
    pulse_rx(8'h07);
    prev = starts_seen;
    idle(20);
    check("timeout_no_tx", 32'(starts_seen), 32'(prev));
    check("timeout_busy", 32'(o_busy), 32'd0);
    check("timeout_hold_A", 32'(o_alu_A), 32'h07);
    run_frame(8'h02, 8'h02, 8'h20, 0, 1'b0, 1'b0, 1'b0);
`endif

    for (int f = 0; f < 40; f++) begin
      opb = 8'($urandom_range(3, 0) * 64) + ops[$urandom_range(7, 0)];
      if ($urandom_range(3, 0) == 0) opb = 8'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        i_tx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_done = 1'b0;
      end
      run_frame(8'($urandom), 8'($urandom_range(255, 0)), opb, 3,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    idle(5);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
